// File: rtl/pentavium_stream_xor.sv
// -----------------------------------------------------------------------------
// pentavium_stream_xor
//
// Purpose
//   Consumer end of the Pentavium keystream interface. Keystream blocks of
//   KS_W bits arrive from the generator and are packed into a bit buffer.
//   Each DATA_W-bit ciphertext beat is XORed with the oldest DATA_W buffered
//   keystream bits to produce a plaintext beat. Encryption uses the same
//   datapath.
//
//   Keystream bits left over at a block boundary stay in the buffer, so no
//   keystream is wasted in the middle of a message. At message end (ct_last)
//   any leftover keystream is discarded.
//
// Ports
//   clk       in   1       single clock, all logic on posedge
//   rst_n     in   1       asynchronous, active-low reset
//   ks_valid  in   1       keystream block valid
//   ks_ready  out  1       block accepted on ks_valid & ks_ready
//   ks_data   in   KS_W    keystream block, bit 0 consumed first
//   ct_valid  in   1       ciphertext beat valid
//   ct_ready  out  1       beat accepted on ct_valid & ct_ready
//   ct_data   in   DATA_W  ciphertext beat, bit 0 pairs with oldest ks bit
//   ct_last   in   1       final beat of message
//   pt_valid  out  1       plaintext beat valid
//   pt_ready  in   1       downstream accepts on pt_valid & pt_ready
//   pt_data   out  DATA_W  plaintext = ct_data ^ keystream bits
//   pt_last   out  1       copy of ct_last for this beat
//   flush     in   1       discard buffered keystream (new IV / resync)
//   blk_cnt   out  CNT_W   keystream blocks accepted since reset, wraps
// -----------------------------------------------------------------------------
module pentavium_stream_xor #(
   parameter int KS_W   = 100,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ks_valid,
   output logic              ks_ready,
   input  logic [KS_W-1:0]   ks_data,
   input  logic              ct_valid,
   output logic              ct_ready,
   input  logic [DATA_W-1:0] ct_data,
   input  logic              ct_last,
   output logic              pt_valid,
   input  logic              pt_ready,
   output logic [DATA_W-1:0] pt_data,
   output logic              pt_last,
   input  logic              flush,
   output logic [CNT_W-1:0]  blk_cnt
);

   // A block is only loaded while fewer than DATA_W bits remain, so the buffer
   // never needs to hold more than (DATA_W-1) + KS_W bits.
   localparam int BUF_W  = KS_W + DATA_W - 1;
   localparam int FILL_W = $clog2(BUF_W + 1);

   localparam logic [FILL_W-1:0] DATA_W_F = FILL_W'(DATA_W);
   localparam logic [FILL_W-1:0] KS_W_F   = FILL_W'(KS_W);

   // The buffer state is fully described by its fill level: either there is
   // enough keystream for one beat (ARMED) or another block is needed.
   typedef enum logic {
      STARVED = 1'b0,
      ARMED   = 1'b1
   } fill_state_t;

   logic [BUF_W-1:0]  ks_buf_q,  ks_buf_d;
   logic [FILL_W-1:0] fill_q,    fill_d;
   fill_state_t       fill_state;

   logic              ks_fire;
   logic              ct_fire;
   logic              pt_slot_free;

   // ---------------------------------------------------------------------------
   // Handshake decode
   // ---------------------------------------------------------------------------
   assign fill_state   = (fill_q >= DATA_W_F) ? ARMED : STARVED;

   // The output register can take a new beat if it is empty or draining now.
   assign pt_slot_free = !pt_valid || pt_ready;

   // Load and consume thresholds are complementary, so at most one fires.
   assign ks_ready = !flush && (fill_state == STARVED);
   assign ct_ready = !flush && (fill_state == ARMED) && pt_slot_free;

   assign ks_fire  = ks_valid && ks_ready;
   assign ct_fire  = ct_valid && ct_ready;

   // ---------------------------------------------------------------------------
   // Keystream buffer next state
   // ---------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      ks_buf_d = ks_buf_q;
      fill_d   = fill_q;

      if (flush) begin
         ks_buf_d = '0;
         fill_d   = '0;
      end else if (ks_fire) begin
         // New bits land directly above the fill level. Bits above the fill
         // level are always zero, so OR acts as a plain insert.
         ks_buf_d = ks_buf_q | (BUF_W'(ks_data) << fill_q);
         fill_d   = fill_q + KS_W_F;
      end else if (ct_fire) begin
         if (ct_last) begin
            // Leftover keystream is discarded at message end.
            ks_buf_d = '0;
            fill_d   = '0;
         end else begin
            ks_buf_d = ks_buf_q >> DATA_W;
            fill_d   = fill_q - DATA_W_F;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments, so every register
   // samples its pre-edge inputs and the order of statements does not matter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ks_buf_q <= '0;
         fill_q   <= '0;
      end else begin
         ks_buf_q <= ks_buf_d;
         fill_q   <= fill_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Plaintext output register
   // ---------------------------------------------------------------------------
   // Data and last only change when a beat is consumed. They therefore hold
   // steady while the downstream stalls. A flush leaves a pending beat intact.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pt_valid <= 1'b0;
         pt_data  <= '0;
         pt_last  <= 1'b0;
      end else if (ct_fire) begin
         pt_valid <= 1'b1;
         pt_data  <= ct_data ^ ks_buf_q[DATA_W-1:0];
         pt_last  <= ct_last;
      end else if (pt_ready) begin
         pt_valid <= 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Block counter (free-running, wraps naturally)
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_cnt <= '0;
      end else if (ks_fire) begin
         blk_cnt <= blk_cnt + 1'b1;
      end
   end

endmodule
